// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage : MIPS decode/issue register feeding the ALU, with load-use  |
// |               hazard detection and stall/flush control.                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        alu_op,
  output logic              out_valid,
  output logic [REG_AW-1:0] dest_reg,
  output logic              reg_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] store_data,
  output logic              illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_CMP = 4'b0100;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic              w_unused;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rs     = REG_AW'(instr[25:21]);
  assign w_rt     = REG_AW'(instr[20:16]);
  assign w_rd     = REG_AW'(instr[15:11]);
  assign w_sext   = DATA_W'(signed'(instr[15:0]));
  assign w_zext   = DATA_W'(instr[15:0]);
  assign w_unused = &{1'b0, instr[10:6]};

  logic              w_legal;
  logic [3:0]        w_op;
  logic [DATA_W-1:0] w_b;
  logic [REG_AW-1:0] w_dest;
  logic              w_we;
  logic              w_mrd;
  logic              w_mwr;
  logic              w_rt_src;

  always_comb begin
    w_legal  = 1'b1;
    w_op     = ALU_ADD;
    w_b      = w_sext;
    w_dest   = '0;
    w_we     = 1'b0;
    w_mrd    = 1'b0;
    w_mwr    = 1'b0;
    w_rt_src = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_b      = rt_data;
        w_dest   = w_rd;
        w_we     = 1'b1;
        w_rt_src = 1'b1;
        case (w_funct)
          6'b100000, 6'b100001: w_op = ALU_ADD;
          6'b100010, 6'b100011: w_op = ALU_SUB;
          6'b100101:            w_op = ALU_OR;
          6'b100100:            w_op = ALU_AND;
          default:              w_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_dest = w_rt;
        w_we   = 1'b1;
      end
      OP_ANDI: begin
        w_op   = ALU_AND;
        w_b    = w_zext;
        w_dest = w_rt;
        w_we   = 1'b1;
      end
      OP_ORI: begin
        w_op   = ALU_OR;
        w_b    = w_zext;
        w_dest = w_rt;
        w_we   = 1'b1;
      end
      OP_LW: begin
        w_dest = w_rt;
        w_we   = 1'b1;
        w_mrd  = 1'b1;
      end
      OP_SW: begin
        w_mwr    = 1'b1;
        w_rt_src = 1'b1;
      end
      OP_BEQ: begin
        w_op     = ALU_CMP;
        w_b      = rt_data;
        w_rt_src = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // A load still in this stage cannot forward to the next instruction yet.
  logic w_hz;
  logic w_accept;

  assign w_hz = out_valid && mem_rd && (dest_reg != '0) &&
                ((dest_reg == w_rs) || (w_rt_src && (dest_reg == w_rt)));
  assign in_ready = !stall && !w_hz;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      dest_reg   <= '0;
      reg_we     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      store_data <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        reg_we    <= 1'b0;
        mem_rd    <= 1'b0;
        mem_wr    <= 1'b0;
      end else if (!stall) begin
        if (w_accept && w_legal) begin
          a          <= rs_data;
          b          <= w_b;
          alu_op     <= w_op;
          out_valid  <= 1'b1;
          dest_reg   <= w_dest;
          reg_we     <= w_we && (w_dest != '0);
          mem_rd     <= w_mrd;
          mem_wr     <= w_mwr;
          store_data <= rt_data;
        end else begin
          // Hazard, idle and unsupported instructions all leave a bubble.
          out_valid <= 1'b0;
          reg_we    <= 1'b0;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          illegal   <= w_accept;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage : scoreboard bench for the id_ex_stage decode register.   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic [4:0]  dest_reg;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] store_data;
  logic        illegal;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
    .flush(flush), .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid),
    .dest_reg(dest_reg), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .store_data(store_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic        we;
    logic        rd;
    logic        wr;
    logic [31:0] store;
    logic        ill;
  } obs_t;

  obs_t sb[$];
  logic rdy_q[$];
  obs_t mst = '0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t capture();
    obs_t o;
    o.valid = out_valid; o.a = a; o.b = b; o.op = alu_op; o.dest = dest_reg;
    o.we = reg_we; o.rd = mem_rd; o.wr = mem_wr; o.store = store_data;
    o.ill = illegal;
    return o;
  endfunction

  // Hide fields whose value carries no meaning for the current instruction.
  function automatic obs_t mask(obs_t e);
    obs_t m = e;
    if (!m.valid) begin
      m.a = '0; m.b = '0; m.op = '0; m.dest = '0; m.store = '0;
    end
    if (!m.we) m.dest = '0;
    if (!m.wr) m.store = '0;
    return m;
  endfunction

  function automatic obs_t model_decode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    obs_t e = '0;
    logic bad = 1'b0;
    logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zx = {16'h0000, ins[15:0]};
    e.valid = 1'b1;
    e.a     = rs;
    e.store = rt;
    case (ins[31:26])
      6'd0: begin
        e.b = rt; e.dest = ins[15:11]; e.we = 1'b1;
        case (ins[5:0])
          6'd32, 6'd33: e.op = 4'd0;
          6'd34, 6'd35: e.op = 4'd1;
          6'd37:        e.op = 4'd2;
          6'd36:        e.op = 4'd3;
          default:      bad = 1'b1;
        endcase
      end
      6'd8, 6'd9: begin e.op = 4'd0; e.b = sx; e.dest = ins[20:16]; e.we = 1'b1; end
      6'd12:      begin e.op = 4'd3; e.b = zx; e.dest = ins[20:16]; e.we = 1'b1; end
      6'd13:      begin e.op = 4'd2; e.b = zx; e.dest = ins[20:16]; e.we = 1'b1; end
      6'd35:      begin e.op = 4'd0; e.b = sx; e.dest = ins[20:16]; e.we = 1'b1; e.rd = 1'b1; end
      6'd43:      begin e.op = 4'd0; e.b = sx; e.wr = 1'b1; end
      6'd4:       begin e.op = 4'd4; e.b = rt; end
      default:    bad = 1'b1;
    endcase
    if (e.dest == 5'd0) e.we = 1'b0;
    if (bad) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic model_hz(obs_t cur, logic [31:0] ins);
    logic rt_src = (ins[31:26] == 6'd0) || (ins[31:26] == 6'd43) || (ins[31:26] == 6'd4);
    return cur.valid && cur.rd && (cur.dest != 5'd0) &&
           ((cur.dest == ins[25:21]) || (rt_src && (cur.dest == ins[20:16])));
  endfunction

  // Drive one cycle of stimulus and queue what the stage must show for it.
  task automatic apply(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                       input logic v, input logic st, input logic fl);
    obs_t nxt;
    logic hz;
    instr = ins; rs_data = rs; rt_data = rt; in_valid = v; stall = st; flush = fl;
    hz = model_hz(mst, ins);
    rdy_q.push_back(!st && !hz);
    nxt = mst;
    nxt.ill = 1'b0;
    if (fl || (!st && (hz || !v))) begin
      nxt.valid = 1'b0; nxt.we = 1'b0; nxt.rd = 1'b0; nxt.wr = 1'b0;
    end else if (!st) begin
      nxt = model_decode(ins, rs, rt);
    end
    mst = nxt;
    sb.push_back(mask(nxt));
  endtask

  task automatic test_reset();
    obs_t g;
    logic r;
    #2 rst_n = 1'b0;
    #1;
    g = capture();
    n_cmp++;
    if (g !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %h required 0", g);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    mst = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      apply(32'h00851022, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL reset_idle[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      g = mask(capture());
      n_cmp++;
      if (g !== sb.pop_front() || out_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_idle[%0d] out_valid: got %b required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [0:12] = '{32'h00851022, 32'h2023FFFC, 32'h3423FFFF, 32'h00851020,
                                32'h00851021, 32'h00851023, 32'h00851025, 32'h00851024,
                                32'h2423FFFC, 32'h3023F0F0, 32'hAC23000C, 32'h10850003,
                                32'h00850020};
    obs_t g, e;
    logic r;
    for (int i = 0; i < 13; i++) begin
      apply(ins[i], (i == 0) ? 32'd10 : 32'h1000 + i, (i == 0) ? 32'd3 : 32'h80000000 + i,
            1'b1, 1'b0, 1'b0);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL decode[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      e = sb.pop_front();
      g = mask(capture());
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL decode[%0d] outputs: got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ins [0:12] = '{32'h8D280000, 32'h01085020, 32'h01085020, 32'h8D200000,
                                32'h00005020, 32'h8D280000, 32'hAC280004, 32'hAC280004,
                                32'h8D280000, 32'h20280005, 32'h8D280000, 32'h21030001,
                                32'h21030001};
    obs_t g, e;
    logic r;
    for (int i = 0; i < 13; i++) begin
      apply(ins[i], 32'h40 + i, 32'h50 + i, 1'b1, 1'b0, 1'b0);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL load_use[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      e = sb.pop_front();
      g = mask(capture());
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL load_use[%0d] outputs: got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] ins [0:10] = '{32'h00851022, 32'h2023FFFC, 32'h2023FFFC, 32'h2023FFFC,
                                32'h2023FFFC, 32'h2023FFFC, 32'h3423FFFF, 32'h8D280000,
                                32'h01085020, 32'h01085020, 32'h01085020};
    logic st [0:10] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    logic fl [0:10] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    obs_t g, e;
    logic r;
    for (int i = 0; i < 11; i++) begin
      apply(ins[i], 32'h700 + i, 32'h900 + i, 1'b1, st[i], fl[i]);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL stall_flush[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      e = sb.pop_front();
      g = mask(capture());
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL stall_flush[%0d] outputs: got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [0:7] = '{32'h0000003F, 32'h2023FFFC, 32'hFC000000, 32'h2023FFFC,
                               32'h00851027, 32'h0000003F, 32'h00851022, 32'h00851022};
    logic v  [0:7] = '{1, 1, 1, 1, 1, 0, 1, 1};
    logic st [0:7] = '{0, 0, 0, 1, 0, 0, 0, 0};
    obs_t g, e;
    logic r;
    for (int i = 0; i < 8; i++) begin
      apply(ins[i], 32'd10, 32'd3, v[i], st[i], 1'b0);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL illegal[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      e = sb.pop_front();
      g = mask(capture());
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL illegal[%0d] outputs: got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops   [0:9] = '{6'd0, 6'd0, 6'd8, 6'd9, 6'd12, 6'd13, 6'd35, 6'd35, 6'd43, 6'd4};
    logic [5:0]  functs[0:6] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42};
    logic [31:0] ins;
    obs_t g, e;
    logic r;
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op = ops[$urandom_range(0, 9)];
      logic [4:0] rs = 5'($urandom_range(0, 7));
      logic [4:0] rt = 5'($urandom_range(0, 7));
      logic [4:0] rd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) op = 6'd63;
      if (op == 6'd0) ins = {op, rs, rt, rd, 5'd0, functs[$urandom_range(0, 6)]};
      else            ins = {op, rs, rt, 16'($urandom())};
      apply(ins, $urandom(), $urandom(), $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
      #1;
      r = rdy_q.pop_front();
      n_cmp++;
      if (in_ready !== r) begin n_bad++; $display("FAIL random[%0d] in_ready: got %b required %b", i, in_ready, r); end
      @(posedge clk); #1;
      e = sb.pop_front();
      g = mask(capture());
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL random[%0d] outputs: got %h required %h", i, g, e); end
    end
  endtask

  task automatic test_async_reset();
    obs_t g, e;
    logic r;
    apply(32'h8D280000, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0);
    #1;
    r = rdy_q.pop_front();
    n_cmp++;
    if (in_ready !== r) begin n_bad++; $display("FAIL async_reset load in_ready: got %b required %b", in_ready, r); end
    @(posedge clk); #1;
    e = sb.pop_front();
    g = mask(capture());
    n_cmp++;
    if (g !== e) begin n_bad++; $display("FAIL async_reset load outputs: got %h required %h", g, e); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    g = capture();
    n_cmp++;
    if (g !== '0) begin n_bad++; $display("FAIL async_reset clear: got %h required 0", g); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    mst = '0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_stall_flush();
    test_illegal();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
